// File: rtl/image_pkg.sv
// Shared types and default widths for the image pipeline stage,
// its frame transmitter and the verification agents.
package image_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int DIM_W_DEF   = 12;
    localparam int BLANK_W_DEF = 8;

    // Encoding 2'd3 is reserved and decodes as PAT_INC.
    typedef enum logic [1:0] {
        PAT_INC   = 2'd0,
        PAT_XY    = 2'd1,
        PAT_CONST = 2'd2
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_BLANK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/image_pattern_gen.sv
// Combinational pixel value generator: maps pattern, seed, coordinates and
// linear pixel index to one beat of data.
module image_pattern_gen
    import image_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  pattern_e          pattern,
    input  logic [DATA_W-1:0] seed,
    input  logic [DIM_W-1:0]  x,
    input  logic [DIM_W-1:0]  y,
    input  logic [DATA_W-1:0] idx,
    output logic [DATA_W-1:0] data
);

    localparam int HALF = DATA_W / 2;

    always_comb begin
        data = seed + idx;
        case (pattern)
            PAT_XY: begin
                // y in the upper half, x in the lower half, both zero-extended
                data                = '0;
                data[DIM_W-1:0]     = x;
                data[HALF +: DIM_W] = y;
            end
            PAT_CONST: data = seed;
            default:   data = seed + idx;
        endcase
    end

endmodule

// File: rtl/image_frame_tx.sv
// Frame-level pixel transmitter: emits width*height beats line by line on a
// valid/busy handshake, with optional inter-line blanking and test patterns.
module image_frame_tx
    import image_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DIM_W   = DIM_W_DEF,
    parameter int BLANK_W = BLANK_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DIM_W-1:0]   cfg_width,
    input  logic [DIM_W-1:0]   cfg_height,
    input  logic [BLANK_W-1:0] cfg_hblank,
    input  logic [1:0]         cfg_pattern,
    input  logic [DATA_W-1:0]  cfg_seed,
    output logic [DATA_W-1:0]  im_data_out,
    output logic               im_valid_out,
    input  logic               im_busy_in,
    output logic               im_sof_out,
    output logic               im_eol_out,
    output logic               active,
    output logic               frame_done
);

    state_e               state_reg, state_next;

    logic [DIM_W-1:0]     width_reg, height_reg;
    logic [BLANK_W-1:0]   hblank_reg;
    pattern_e             pattern_reg;
    logic [DATA_W-1:0]    seed_reg;

    logic [DIM_W-1:0]     x_reg, x_next;
    logic [DIM_W-1:0]     y_reg, y_next;
    logic [DATA_W-1:0]    idx_reg, idx_next;
    logic [BLANK_W-1:0]   blank_cnt_reg, blank_cnt_next;

    logic [DATA_W-1:0]    data_reg, data_next;
    logic                 valid_reg, valid_next;
    logic                 sof_reg, sof_next;
    logic                 eol_reg, eol_next;
    logic                 active_reg, active_next;
    logic                 done_reg, done_next;

    logic                 load_cfg, cfg_nonzero, transfer;
    logic                 last_x, last_y, blank_end, present;
    logic [DIM_W-1:0]     width_sel;
    pattern_e             pattern_sel;
    logic [DATA_W-1:0]    seed_sel, gen_data;

    assign load_cfg    = (state_reg == ST_IDLE) && start;
    assign cfg_nonzero = (cfg_width != '0) && (cfg_height != '0);
    assign transfer    = valid_reg && !im_busy_in;
    assign last_x      = (x_reg == width_reg - DIM_W'(1));
    assign last_y      = (y_reg == height_reg - DIM_W'(1));
    assign blank_end   = (blank_cnt_reg == hblank_reg - BLANK_W'(1));

    // Beat 0 is produced on the accepting edge, before the latched copies exist.
    assign width_sel   = (state_reg == ST_IDLE) ? cfg_width : width_reg;
    assign pattern_sel = (state_reg == ST_IDLE) ? pattern_e'(cfg_pattern) : pattern_reg;
    assign seed_sel    = (state_reg == ST_IDLE) ? cfg_seed : seed_reg;

    image_pattern_gen #(
        .DATA_W (DATA_W),
        .DIM_W  (DIM_W)
    ) u_pattern_gen (
        .pattern (pattern_sel),
        .seed    (seed_sel),
        .x       (x_next),
        .y       (y_next),
        .idx     (idx_next),
        .data    (gen_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = cfg_nonzero ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (transfer && last_x) begin
                    if (last_y) begin
                        state_next = ST_DONE;
                    end else if (hblank_reg != '0) begin
                        state_next = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (blank_end) begin
                    state_next = ST_SEND;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the coordinate counters and of every registered output.
    always_comb begin
        present        = 1'b0;
        x_next         = x_reg;
        y_next         = y_reg;
        idx_next       = idx_reg;
        blank_cnt_next = blank_cnt_reg;
        valid_next     = valid_reg;
        sof_next       = sof_reg;
        eol_next       = eol_reg;
        active_next    = active_reg;
        done_next      = (state_reg == ST_DONE);
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    x_next   = '0;
                    y_next   = '0;
                    idx_next = '0;
                    if (cfg_nonzero) begin
                        present     = 1'b1;
                        active_next = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (transfer) begin
                    idx_next = idx_reg + DATA_W'(1);
                    if (!last_x) begin
                        x_next  = x_reg + DIM_W'(1);
                        present = 1'b1;
                    end else if (!last_y) begin
                        x_next         = '0;
                        y_next         = y_reg + DIM_W'(1);
                        blank_cnt_next = '0;
                        if (hblank_reg == '0) begin
                            present = 1'b1;
                        end else begin
                            valid_next = 1'b0;
                        end
                    end else begin
                        valid_next  = 1'b0;
                        active_next = 1'b0;
                    end
                end
            end
            ST_BLANK: begin
                if (blank_end) begin
                    present = 1'b1;
                end else begin
                    blank_cnt_next = blank_cnt_reg + BLANK_W'(1);
                end
            end
            default: ;
        endcase
        if (present) begin
            valid_next = 1'b1;
            sof_next   = (x_next == '0) && (y_next == '0);
            eol_next   = (x_next == width_sel - DIM_W'(1));
        end else if (!valid_next) begin
            sof_next = 1'b0;
            eol_next = 1'b0;
        end
    end

    assign data_next = present ? gen_data : data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_reg     <= '0;
            height_reg    <= '0;
            hblank_reg    <= '0;
            pattern_reg   <= PAT_INC;
            seed_reg      <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            idx_reg       <= '0;
            blank_cnt_reg <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            sof_reg       <= 1'b0;
            eol_reg       <= 1'b0;
            active_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            if (load_cfg) begin
                width_reg   <= cfg_width;
                height_reg  <= cfg_height;
                hblank_reg  <= cfg_hblank;
                pattern_reg <= pattern_e'(cfg_pattern);
                seed_reg    <= cfg_seed;
            end
            x_reg         <= x_next;
            y_reg         <= y_next;
            idx_reg       <= idx_next;
            blank_cnt_reg <= blank_cnt_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            sof_reg       <= sof_next;
            eol_reg       <= eol_next;
            active_reg    <= active_next;
            done_reg      <= done_next;
        end
    end

    assign im_data_out  = data_reg;
    assign im_valid_out = valid_reg;
    assign im_sof_out   = sof_reg;
    assign im_eol_out   = eol_reg;
    assign active       = active_reg;
    assign frame_done   = done_reg;

endmodule

// File: doc/image_frame_tx.md
Name: image_frame_tx

Overview:
- Frame-level pixel transmitter that drives the slave (is_*) side of the image pipeline stage.
- On a start command it emits exactly width*height 32-bit pixel beats, line by line.
- Uses the pipeline's valid/busy handshake, with an optional blanking gap between lines and a selectable test pattern.
- Acts as the stimulus source for the image pipe datapath and as the synthesizable pattern generator for bring-up.

Parameters:
DATA_W, 32, pixel/beat width; XY pattern requires DATA_W >= 2*DIM_W
DIM_W, 12, width/height/coordinate counter width (max 4095 per dimension)
BLANK_W, 8, inter-line blanking counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle frame request; honoured only in IDLE
cfg_width  in  DIM_W  pixels per line, latched at start
cfg_height  in  DIM_W  lines per frame, latched at start
cfg_hblank  in  BLANK_W  idle cycles between lines, latched at start
cfg_pattern  in  2  0=INC, 1=XY, 2=CONST, 3=reserved (behaves as INC)
cfg_seed  in  DATA_W  base value for INC/CONST, latched at start
im_data_out  out  DATA_W  pixel beat
im_valid_out  out  1  beat valid
im_busy_in  in  1  downstream backpressure
im_sof_out  out  1  sideband, high with first beat of frame
im_eol_out  out  1  sideband, high with last beat of each line
active  out  1  high from start acceptance until last beat accepted
frame_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, all counters 0. Reset mid-frame aborts immediately; no completion pulse.
- Transfer rule: a beat transfers on a rising edge where im_valid_out=1 and im_busy_in=0.
- Hold rule: while im_valid_out=1 and im_busy_in=1, im_data_out, im_sof_out and im_eol_out hold stable and valid stays high.
- All outputs are registered.
- FSM states: IDLE, SEND, BLANK, DONE.
- IDLE:
  - start=1 latches cfg_*.
  - width>0 and height>0: go to SEND, load x=0, y=0, assert valid with beat 0 on the next edge. Latency start->valid = 1 cycle.
  - width=0 or height=0: go to DONE, zero beats.
- SEND: on each transfer, advance x.
  - Beat with x=width-1 accepted and y<height-1: x=0, y++.
    - hblank>0: go to BLANK, drop valid.
    - hblank=0: next line's beat 0 follows on the next edge; valid stays high.
  - Beat with x=width-1, y=height-1 accepted: drop valid, go to DONE.
- BLANK: valid=0 for exactly cfg_hblank cycles, then SEND with the next line's first beat presented.
- DONE: frame_done=1 and active=0 for one cycle, then IDLE.
- start while not IDLE (including DONE): ignored.
- start in the first IDLE cycle after DONE: accepted.
- Patterns (i = linear pixel index):
  - INC: data = seed + i, modulo 2^DATA_W; wraps silently.
  - XY: data = {y zero-extended to DATA_W/2, x zero-extended to DATA_W/2}.
  - CONST: data = seed.
- Sideband flags:
  - im_sof_out=1 only on beat x=0, y=0.
  - im_eol_out=1 on every beat with x=width-1. For width=1, every beat has eol=1.
- cfg_* changes after start have no effect until the next start.
- im_busy_in while valid=0 is ignored; no stall is counted.

Decomposition:
- Package image_pkg:
  - pattern enum (PAT_INC, PAT_XY, PAT_CONST)
  - FSM state enum
  - DATA_W / DIM_W defaults
- Shared with the pipeline stage and the UVM agents.
- Natural sub-module: image_pattern_gen. It is combinational from (pattern, seed, x, y, i) to data, and lets the output register stay in image_frame_tx.

Test Plan:
- width=4, height=2, hblank=0, INC, seed=0x10, busy=0 -> 8 back-to-back beats 0x10..0x17; sof on beat 0; eol on beats 3 and 7; frame_done 1 cycle after beat 7.
- width=3, height=2, hblank=5, XY -> beats 0x0,0x1,0x2, then exactly 5 valid-low cycles, then 0x10000,0x10001,0x10002.
- width=4, height=1, INC, busy high for 3 cycles during beat 2 -> beat 2 data/eol held stable for 4 cycles; total 4 transfers; no duplicates or skips.
- width=0, height=5, start -> no valid ever; frame_done pulses 2 cycles after start; start asserted during SEND of another frame is ignored (beat count unchanged).
- INC, seed=0xFFFFFFFE, width=4, height=1 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst_n low asynchronously mid-line (beat 5 of 16) -> valid, active, sof and eol drop without a clock edge; no frame_done; a new start after reset begins at beat 0 with sof.
